// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants and accumulator FSM states.
package fp32_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input yields 25.
module fp32_lzc (
    input  logic [24:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd25;
        // Ascending scan: the highest set bit is the last one written.
        for (int unsigned i = 0; i < 25; i++) begin
            if (value[i]) begin
                count = 5'(24 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_stream_accumulator.sv
// Sums a framed stream of FP32 elements with a four-step sequential adder
// (truncating, denormals flushed, overflow saturating to infinity).
module fp32_stream_accumulator
    import fp32_pkg::*;
#(
    parameter int unsigned COUNT_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);

    state_t state, state_next;

    logic [31:0]        acc;
    logic [COUNT_W-1:0] count;
    logic               ovf;
    logic [31:0]        op_r;
    logic               last_r;

    logic [23:0]        al_a, al_b;
    logic               sign_a, sign_b;
    logic [EXP_W-1:0]   exp_r;

    logic [24:0]        sum_r;
    logic               sign_r;

    logic               take;
    logic               acc_inf;

    // Alignment combinational results
    logic [EXP_W-1:0]   ea, eb, diff;
    logic [23:0]        sig_a, sig_b;
    logic [23:0]        al_a_c, al_b_c;
    logic [EXP_W-1:0]   exp_c;

    // Normalization combinational results
    logic [4:0]         lz;
    logic [4:0]         shift;
    logic signed [9:0]  e_norm;
    logic [MAN_W-1:0]   man_shift;
    logic [31:0]        norm_res;
    logic               norm_ovf;

    assign take    = in_valid && in_ready;
    assign acc_inf = (acc[30:23] == 8'hFF);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    fp32_lzc u_lzc (
        .value (sum_r),
        .count (lz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = last_r ? DONE : IDLE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ea     = acc[30:23];
        eb     = op_r[30:23];
        sig_a  = (ea == '0) ? '0 : {1'b1, acc[22:0]};
        sig_b  = (eb == '0) ? '0 : {1'b1, op_r[22:0]};
        al_a_c = sig_a;
        al_b_c = sig_b;
        if (ea >= eb) begin
            diff   = ea - eb;
            exp_c  = ea;
            al_b_c = (diff >= 8'd25) ? '0 : (sig_b >> diff);
        end else begin
            diff   = eb - ea;
            exp_c  = eb;
            al_a_c = (diff >= 8'd25) ? '0 : (sig_a >> diff);
        end
    end

    always_comb begin
        shift     = lz - 5'd1;
        e_norm    = '0;
        man_shift = sum_r[22:0] << shift;
        norm_res  = FP32_ZERO;
        norm_ovf  = 1'b0;
        if (acc_inf) begin
            norm_res = acc;
        end else if (sum_r == '0) begin
            norm_res = FP32_ZERO;
        end else if (sum_r[24]) begin
            e_norm = $signed({2'b00, exp_r}) + 10'sd1;
            if (e_norm >= 10'sd255) begin
                norm_res = {sign_r, FP32_POS_INF[30:0]};
                norm_ovf = 1'b1;
            end else begin
                norm_res = {sign_r, e_norm[7:0], sum_r[23:1]};
            end
        end else begin
            // Hidden bit lands at bit 23 after shifting by lz-1.
            e_norm = $signed({2'b00, exp_r}) - $signed({5'b00000, shift});
            if (e_norm <= 10'sd0) begin
                norm_res = FP32_ZERO;
            end else begin
                norm_res = {sign_r, e_norm[7:0], man_shift};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= FP32_ZERO;
            count  <= '0;
            ovf    <= 1'b0;
            op_r   <= '0;
            last_r <= 1'b0;
            al_a   <= '0;
            al_b   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            exp_r  <= '0;
            sum_r  <= '0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        op_r   <= (in_data[30:23] == '0) ? FP32_ZERO : in_data;
                        last_r <= in_last;
                        if (count != '1) count <= count + 1'b1;
                        if (in_data[30:23] == 8'hFF) begin
                            acc <= FP32_POS_INF;
                            ovf <= 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    al_a   <= al_a_c;
                    al_b   <= al_b_c;
                    exp_r  <= exp_c;
                    sign_a <= acc[31];
                    sign_b <= op_r[31];
                end
                ADD: begin
                    if (sign_a == sign_b) begin
                        sum_r  <= {1'b0, al_a} + {1'b0, al_b};
                        sign_r <= sign_a;
                    end else if (al_a >= al_b) begin
                        sum_r  <= {1'b0, al_a - al_b};
                        sign_r <= sign_a;
                    end else begin
                        sum_r  <= {1'b0, al_b - al_a};
                        sign_r <= sign_b;
                    end
                end
                NORM: begin
                    acc <= norm_res;
                    if (norm_ovf) ovf <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= FP32_ZERO;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Directed bench for fp32_stream_accumulator with hand-computed frame sums.
module tb_fp32_stream_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [9:0]  out_count;
    logic        out_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_stream_accumulator #(.COUNT_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get(input string tag, input logic [31:0] d, input logic [31:0] c, input logic o);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, {22'b0, out_count}, c);
        check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, o});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_count", {22'b0, out_count}, 32'd0);
        check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        #12 rst_n = 1'b1;

        // 1 + 2 + 3, with in_ready dropping for three cycles after each accept
        send(32'h3F800000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_after_accept", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        check("ready_again", {31'b0, in_ready}, 32'd1);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        get("sum123", 32'h40C00000, 32'd3, 1'b0);

        // 4 x 255.0
        for (int i = 0; i < 4; i++) send(32'h437F0000, i == 3);
        get("sum255x4", 32'h447F0000, 32'd4, 1'b0);

        // Truncation and cancellation
        send(32'h4B800000, 1'b0);
        send(32'h3F800000, 1'b1);
        get("trunc_big", 32'h4B800000, 32'd2, 1'b0);
        send(32'h40A00000, 1'b0);
        send(32'hC0400000, 1'b1);
        get("sub_5m3", 32'h40000000, 32'd2, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'hC0400000, 1'b1);
        get("cancel", 32'h00000000, 32'd2, 1'b0);

        // Denormal flush, overflow saturation, Inf/NaN input
        send(32'h00000001, 1'b1);
        get("denorm", 32'h00000000, 32'd1, 1'b0);
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);
        get("overflow", 32'h7F800000, 32'd2, 1'b1);
        send(32'h3F800000, 1'b0);
        send(32'h7FC00000, 1'b1);
        get("nan_in", 32'h7F800000, 32'd2, 1'b1);

        // Back-pressure in DONE: outputs hold, input ignored
        send(32'h40000000, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        in_valid = 1'b1;
        in_data  = 32'h41200000;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", out_data, 32'h40000000);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        get("hold_release", 32'h40000000, 32'd1, 1'b0);
        send(32'h40400000, 1'b1);
        get("after_hold", 32'h40400000, 32'd1, 1'b0);

        // Asynchronous reset during ALIGN of the second element
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("async_in_ready", {31'b0, in_ready}, 32'd1);
        check("async_out_count", {22'b0, out_count}, 32'd0);
        check("async_out_data", out_data, 32'h0);
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h3F800000, 1'b1);
        get("post_reset", 32'h3F800000, 32'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
